dma_serv: RTL and testbench

DMA_SERV -- requirements
Module: dma_serv

---
 rtl/dma_pkg.sv | 14 +
 rtl/dma_mem.sv | 24 ++
 rtl/dma_serv.sv | 130 +++++++++++++
 tb/tb_dma_serv.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared bus widths, default parameters and FSM state type for dma_serv
package dma_pkg;

    localparam int BUS_ADDR_W    = 17;
    localparam int BUS_DATA_W    = 8;
    localparam int DEF_MEM_DEPTH = 1024;
    localparam int DEF_RD_LAT    = 2;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } dma_state_e;

endpackage

// File: rtl/dma_mem.sv
// rtl/dma_mem.sv - single-port byte RAM, synchronous write, combinational read
module dma_mem #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dma_serv.sv
// rtl/dma_serv.sv - byte-wide bus slave with fixed read latency and per-location written flags
module dma_serv
    import dma_pkg::*;
#(
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int RD_LAT    = DEF_RD_LAT
) (
    input  logic                  bus_clk,
    input  logic                  rstn,
    output logic                  bus_ready,
    output logic                  bus_rdata_ready,
    output logic [BUS_DATA_W-1:0] bus_rdata,
    input  logic [BUS_ADDR_W-1:0] bus_addr,
    input  logic [BUS_DATA_W-1:0] bus_wdata,
    input  logic                  bus_rd,
    input  logic                  bus_wr
);

    localparam int AW    = $clog2(MEM_DEPTH);
    localparam int CNT_W = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    dma_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  rvalid_q, rvalid_d;
    logic [BUS_DATA_W-1:0] rdata_q, rdata_d;
    logic [BUS_DATA_W-1:0] hold_q, hold_d;
    logic [MEM_DEPTH-1:0]  written_q;

    logic [AW-1:0]         idx;
    logic [BUS_DATA_W-1:0] mem_rdata;
    logic [BUS_DATA_W-1:0] rd_sample;
    logic                  acc_rd;
    logic                  acc_wr;

    assign idx    = bus_addr[AW-1:0];
    assign acc_wr = bus_wr & ready_q;
    assign acc_rd = bus_rd & ready_q;

    // A same-cycle write wins, so the read returns the byte being written;
    // never-written locations read back their own low address byte.
    assign rd_sample = acc_wr             ? bus_wdata :
                       written_q[idx]     ? mem_rdata :
                                            bus_addr[BUS_DATA_W-1:0];

    generate
        if (AW < BUS_ADDR_W) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^bus_addr[BUS_ADDR_W-1:AW];
        end
    endgenerate

    dma_mem #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW),
        .DW    (BUS_DATA_W)
    ) u_mem (
        .clk_i   (bus_clk),
        .we_i    (acc_wr),
        .addr_i  (idx),
        .wdata_i (bus_wdata),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (acc_rd) begin
                    if (RD_LAT == 1) begin
                        rdata_d  = rd_sample;
                        rvalid_d = 1'b1;
                    end else begin
                        hold_d  = rd_sample;
                        cnt_d   = CNT_LOAD;
                        state_d = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q == CNT_ONE) begin
                    rdata_d  = hold_q;
                    rvalid_d = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge bus_clk or posedge rstn) begin
        if (rstn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            hold_q   <= hold_d;
        end
    end

    always_ff @(posedge bus_clk or posedge rstn) begin
        if (rstn) begin
            written_q <= '0;
        end else if (acc_wr) begin
            written_q[idx] <= 1'b1;
        end
    end

    assign bus_ready       = ready_q;
    assign bus_rdata_ready = rvalid_q;
    assign bus_rdata       = rdata_q;

endmodule

// File: tb/tb_dma_serv.sv
// tb/tb_dma_serv.sv - randomized and directed self-checking bench for dma_serv against a behavioural model
module tb_dma_serv;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd    [2];
    logic        wr    [2];
    logic [16:0] addr  [2];
    logic [7:0]  wdata [2];
    logic        ready [2];
    logic        rv    [2];
    logic [7:0]  rdata [2];

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    always #5 clk = ~clk;

    dma_serv #(.MEM_DEPTH(DEPTH), .RD_LAT(2)) u_dut0 (
        .bus_clk(clk), .rstn(rst), .bus_ready(ready[0]), .bus_rdata_ready(rv[0]),
        .bus_rdata(rdata[0]), .bus_addr(addr[0]), .bus_wdata(wdata[0]),
        .bus_rd(rd[0]), .bus_wr(wr[0]));

    dma_serv #(.MEM_DEPTH(DEPTH), .RD_LAT(1)) u_dut1 (
        .bus_clk(clk), .rstn(rst), .bus_ready(ready[1]), .bus_rdata_ready(rv[1]),
        .bus_rdata(rdata[1]), .bus_addr(addr[1]), .bus_wdata(wdata[1]),
        .bus_rd(rd[1]), .bus_wr(wr[1]));

    function automatic int lat(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Behavioural model: a read accepted at edge e completes at edge e+lat-1;
    // the slave is ready whenever no read is pending and reset is released.
    logic [7:0]       m_mem   [2][DEPTH];
    bit [DEPTH-1:0]   m_wr    [2];
    bit               m_ready [2];
    bit               m_rv    [2];
    bit               m_busy  [2];
    logic [7:0]       m_rdata [2];
    logic [7:0]       m_pend  [2];
    int               m_due   [2];
    int               edge_n = 0;

    always @(posedge clk) begin : model
        int         e;
        int         ix;
        bit         aw, ar, busy, pulse;
        logic [7:0] d, out;
        e = edge_n + 1;
        edge_n <= e;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_ready[k] <= 1'b0;
                m_rv[k]    <= 1'b0;
                m_busy[k]  <= 1'b0;
                m_rdata[k] <= 8'h00;
                m_wr[k]    <= '0;
            end else begin
                ix    = int'(addr[k]) % DEPTH;
                aw    = wr[k] && m_ready[k];
                ar    = rd[k] && m_ready[k];
                d     = aw ? wdata[k] : (m_wr[k][ix] ? m_mem[k][ix] : addr[k][7:0]);
                busy  = m_busy[k];
                pulse = 1'b0;
                out   = m_rdata[k];
                if (aw) begin
                    m_mem[k][ix] <= wdata[k];
                    m_wr[k][ix]  <= 1'b1;
                end
                if (busy && e == m_due[k]) begin
                    pulse = 1'b1;
                    out   = m_pend[k];
                    busy  = 1'b0;
                end
                if (ar) begin
                    if (lat(k) == 1) begin
                        pulse = 1'b1;
                        out   = d;
                    end else begin
                        busy      = 1'b1;
                        m_due[k]  <= e + lat(k) - 1;
                        m_pend[k] <= d;
                    end
                end
                m_busy[k]  <= busy;
                m_rv[k]    <= pulse;
                m_rdata[k] <= out;
                m_ready[k] <= !busy;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("ready%0d", k), 32'(ready[k]), 32'(m_ready[k]));
                check($sformatf("rvalid%0d", k), 32'(rv[k]), 32'(m_rv[k]));
                check($sformatf("rdata%0d", k), 32'(rdata[k]), 32'(m_rdata[k]));
            end
        end
    end

    bit ph31  = 1'b0;
    int p31   = 0;
    int l31   = 0;

    always @(negedge clk) begin
        if (ph31) begin
            if (rv[1] === 1'b1) p31++;
            if (ready[1] !== 1'b1) l31++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input int k);
        int n = 0;
        while (ready[k] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check($sformatf("wait_ready%0d_timeout", k), 32'(ready[k]), 32'd1);
    endtask

    task automatic wr_byte(input int k, input logic [16:0] a, input logic [7:0] d);
        wait_ready(k);
        wr[k] = 1'b1; addr[k] = a; wdata[k] = d;
        tick();
        wr[k] = 1'b0;
    endtask

    task automatic wait_pulse(input int k, input logic [7:0] exp, input string nm, output int low);
        int n = 0;
        low = 0;
        while (rv[k] !== 1'b1 && n < 10) begin
            if (ready[k] !== 1'b1) low++;
            tick();
            n++;
        end
        check({nm, "_latency"}, 32'(n), 32'(lat(k) - 1));
        check({nm, "_data"}, 32'(rdata[k]), 32'(exp));
    endtask

    task automatic rd_byte(input int k, input logic [16:0] a, input bit also_wr, input logic [7:0] wd,
                           input logic [7:0] exp, input string nm, output int low);
        wait_ready(k);
        rd[k] = 1'b1; addr[k] = a; wr[k] = also_wr; wdata[k] = wd;
        tick();
        rd[k] = 1'b0; wr[k] = 1'b0;
        wait_pulse(k, exp, nm, low);
    endtask

    logic [7:0] d31 [512];

    initial begin
        int low;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
        end
        @(posedge clk);
        #1 chk_en = 1'b1;
        check("reset_ready", 32'(ready[0]), 32'd0);
        check("reset_rdata", 32'(rdata[0]), 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("ready_after_release", 32'(ready[0]), 32'd1);

        rd_byte(0, 17'h00013, 1'b0, 8'h00, 8'h13, "unwritten_read", low);
        check("unwritten_read_ready_low", 32'(low), 32'd1);

        wr_byte(0, 17'h00010, 8'hA5);
        rd_byte(0, 17'h00010, 1'b0, 8'h00, 8'hA5, "written_read", low);
        rd_byte(0, 17'h00410, 1'b0, 8'h00, 8'hA5, "wrap_read", low);

        rd_byte(0, 17'h00020, 1'b1, 8'h3C, 8'h3C, "rd_wr_same_cycle", low);

        wait_ready(0);
        rd[0] = 1'b1; addr[0] = 17'h00040;
        tick();
        rd[0] = 1'b0;
        check("busy_write_ready", 32'(ready[0]), 32'd0);
        wr[0] = 1'b1; addr[0] = 17'h00030; wdata[0] = 8'hFF;
        tick();
        wr[0] = 1'b0;
        check("busy_read_data", 32'(rdata[0]), 32'h40);
        rd_byte(0, 17'h00030, 1'b0, 8'h00, 8'h30, "dropped_write", low);

        wait_ready(0);
        rd[0] = 1'b1; addr[0] = 17'h00050;
        tick();
        rd[0] = 1'b0;
        rst = 1'b1;
        tick();
        check("midreset_rvalid", 32'(rv[0]), 32'd0);
        check("midreset_rdata", 32'(rdata[0]), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_reset_ready", 32'(ready[0]), 32'd1);
        check("post_reset_rvalid", 32'(rv[0]), 32'd0);
        check("post_reset_rdata", 32'(rdata[0]), 32'd0);
        rd_byte(0, 17'h00010, 1'b0, 8'h00, 8'h10, "flags_cleared", low);

        ph31 = 1'b1;
        for (int i = 0; i < 512; i++) begin
            d31[i] = 8'($urandom);
            wr_byte(1, 17'(i), d31[i]);
        end
        for (int i = 0; i < 512; i++) begin
            rd_byte(1, 17'(i), 1'b0, 8'h00, d31[i], "lat1_read", low);
        end
        ph31 = 1'b0;
        check("lat1_pulse_count", 32'(p31), 32'd512);
        check("lat1_ready_low_cycles", 32'(l31), 32'd0);

        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                rd[k]    = ($urandom_range(0, 2) == 0);
                wr[k]    = ($urandom_range(0, 2) == 0);
                addr[k]  = 17'($urandom_range(0, 63)) | (17'($urandom_range(0, 127)) << 10);
                wdata[k] = 8'($urandom);
            end
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rd[k] = 1'b0; wr[k] = 1'b0;
        end
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
